// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit. One data-bus transaction per memory op,
// big-endian byte/halfword lane steering, stall request until the result is ready.
// Optional feature macro: LSU_LLSC_EN (enables LL/SC link tracking via LLbit).
module mem_lsu #(
   parameter int unsigned BUS_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_wreg_i,
   input  logic [4:0]  mem_wd_i,
   input  logic [31:0] mem_wdata_i,
   input  logic        mem_whilo_i,
   input  logic [31:0] mem_hi_i,
   input  logic [31:0] mem_lo_i,
   input  logic [7:0]  mem_aluop_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_reg2_i,
   input  logic [5:0]  stall,
   input  logic        LLbit_i,
   input  logic        wb_LLbit_we,
   input  logic        wb_LLbit_value,
   input  logic        dbus_ack,
   input  logic [31:0] dbus_rdata,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [3:0]  dbus_sel,
   output logic [31:0] dbus_wdata,
   output logic        mem_wreg,
   output logic [4:0]  mem_wd,
   output logic [31:0] mem_wdata,
   output logic        mem_whilo,
   output logic [31:0] mem_hi,
   output logic [31:0] mem_lo,
   output logic        mem_LLbit_we,
   output logic        mem_LLbit_value,
   output logic        mem_addr_err,
   output logic        mem_bus_err,
   output logic        stallreq
);

   localparam int unsigned    CNT_W   = 8;
   localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(BUS_TIMEOUT);
   localparam logic           NO_STOP = 1'b0;

   localparam logic [7:0] OP_LB  = 8'b1110_0000;
   localparam logic [7:0] OP_LBU = 8'b1110_0100;
   localparam logic [7:0] OP_LH  = 8'b1110_0001;
   localparam logic [7:0] OP_LHU = 8'b1110_0101;
   localparam logic [7:0] OP_LW  = 8'b1110_0011;
   localparam logic [7:0] OP_LL  = 8'b1111_0000;
   localparam logic [7:0] OP_SB  = 8'b1110_1000;
   localparam logic [7:0] OP_SH  = 8'b1110_1001;
   localparam logic [7:0] OP_SW  = 8'b1110_1011;
   localparam logic [7:0] OP_SC  = 8'b1111_1000;

   typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      rdata_q;

   // Instruction context captured at issue so the bus and result stay stable while busy
   logic [7:0]  op_q;
   logic [31:0] addr_q, reg2_q, wdata_q, hi_q, lo_q;
   logic [4:0]  wd_q;
   logic        wreg_q, whilo_q;

   logic        busy;
   logic [7:0]  c_op;
   logic [31:0] c_addr, c_reg2, c_wdata, c_hi, c_lo;
   logic [4:0]  c_wd;
   logic        c_wreg, c_whilo;

   assign busy    = (state != IDLE);
   assign c_op    = busy ? op_q    : mem_aluop_i;
   assign c_addr  = busy ? addr_q  : mem_addr_i;
   assign c_reg2  = busy ? reg2_q  : mem_reg2_i;
   assign c_wdata = busy ? wdata_q : mem_wdata_i;
   assign c_hi    = busy ? hi_q    : mem_hi_i;
   assign c_lo    = busy ? lo_q    : mem_lo_i;
   assign c_wd    = busy ? wd_q    : mem_wd_i;
   assign c_wreg  = busy ? wreg_q  : mem_wreg_i;
   assign c_whilo = busy ? whilo_q : mem_whilo_i;

   logic is_load, is_store, is_signed, size_b, size_h, is_ll, is_sc, is_mem, misalign;

   // Opcode decode into access class and size
   always_comb begin
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_signed = 1'b0;
      size_b    = 1'b0;
      size_h    = 1'b0;
      is_ll     = 1'b0;
      is_sc     = 1'b0;
      case (c_op)
         OP_LB:   begin is_load = 1'b1; size_b = 1'b1; is_signed = 1'b1; end
         OP_LBU:  begin is_load = 1'b1; size_b = 1'b1; end
         OP_LH:   begin is_load = 1'b1; size_h = 1'b1; is_signed = 1'b1; end
         OP_LHU:  begin is_load = 1'b1; size_h = 1'b1; end
         OP_LW:   is_load = 1'b1;
         OP_LL:   begin is_load = 1'b1; is_ll = 1'b1; end
         OP_SB:   begin is_store = 1'b1; size_b = 1'b1; end
         OP_SH:   begin is_store = 1'b1; size_h = 1'b1; end
         OP_SW:   is_store = 1'b1;
         OP_SC:   begin is_store = 1'b1; is_sc = 1'b1; end
         default: ;
      endcase
   end

   assign is_mem   = is_load | is_store;
   assign misalign = size_h ? c_addr[0] : (!size_b && (c_addr[1:0] != 2'b00));

   logic [3:0]  sel;
   logic [31:0] st_data, rword, ld_data;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Big-endian lane select and store-data replication
   always_comb begin
      if (size_b) begin
         sel     = 4'b1000 >> c_addr[1:0];
         st_data = {4{c_reg2[7:0]}};
      end else if (size_h) begin
         sel     = c_addr[1] ? 4'b0011 : 4'b1100;
         st_data = {2{c_reg2[15:0]}};
      end else begin
         sel     = 4'b1111;
         st_data = c_reg2;
      end
   end

   assign rword   = (state == HOLD) ? rdata_q : dbus_rdata;
   assign ld_byte = rword[{~c_addr[1:0], 3'b000} +: 8];
   assign ld_half = rword[{~c_addr[1], 4'b0000} +: 16];

   // Load data extraction with sign/zero extension
   always_comb begin
      if (size_b)      ld_data = is_signed ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
      else if (size_h) ld_data = is_signed ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
      else             ld_data = rword;
   end

   logic sc_fail, link_en;
`ifdef LSU_LLSC_EN
   assign sc_fail = is_sc & ~(wb_LLbit_we ? wb_LLbit_value : LLbit_i);
   assign link_en = 1'b1;
`else
   logic unused_llbit;
   assign unused_llbit = LLbit_i ^ wb_LLbit_we ^ wb_LLbit_value;
   assign sc_fail      = 1'b0;
   assign link_en      = 1'b0;
`endif

   logic issue, timeout, done, drive;
   assign issue   = (state == IDLE) && rst && is_mem && !misalign && !sc_fail;
   assign timeout = (state == ACCESS) && (cnt == TIMEOUT);
   assign done    = (state == ACCESS) && !timeout && dbus_ack;
   assign drive   = issue || (rst && (state == ACCESS) && !timeout);

   // FSM, timeout counter, read-data latch and context capture
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         rdata_q <= '0;
         op_q    <= '0;
         addr_q  <= '0;
         reg2_q  <= '0;
         wdata_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         wd_q    <= '0;
         wreg_q  <= 1'b0;
         whilo_q <= 1'b0;
      end else begin
         case (state)
            IDLE: if (issue) begin
               state   <= ACCESS;
               cnt     <= '0;
               op_q    <= mem_aluop_i;
               addr_q  <= mem_addr_i;
               reg2_q  <= mem_reg2_i;
               wdata_q <= mem_wdata_i;
               hi_q    <= mem_hi_i;
               lo_q    <= mem_lo_i;
               wd_q    <= mem_wd_i;
               wreg_q  <= mem_wreg_i;
               whilo_q <= mem_whilo_i;
            end
            ACCESS: begin
               if (timeout) begin
                  state <= IDLE;
               end else if (dbus_ack) begin
                  if (is_load) rdata_q <= dbus_rdata;
                  state <= (stall != 6'b000000) ? HOLD : IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            HOLD: if (stall[4] == NO_STOP) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Bus drive, stall request and result formatting toward mem_wb
   always_comb begin
      mem_wreg        = c_wreg;
      mem_wd          = c_wd;
      mem_wdata       = c_wdata;
      mem_whilo       = c_whilo;
      mem_hi          = c_hi;
      mem_lo          = c_lo;
      mem_LLbit_we    = 1'b0;
      mem_LLbit_value = 1'b0;
      mem_addr_err    = 1'b0;
      mem_bus_err     = 1'b0;
      dbus_req        = 1'b0;
      dbus_we         = 1'b0;
      dbus_addr       = '0;
      dbus_sel        = '0;
      dbus_wdata      = '0;
      stallreq        = issue || (rst && (state == ACCESS) && !timeout && !dbus_ack);
      if (drive) begin
         dbus_req   = 1'b1;
         dbus_we    = is_store;
         dbus_addr  = {c_addr[31:2], 2'b00};
         dbus_sel   = sel;
         dbus_wdata = is_store ? st_data : 32'h0;
      end
      if ((state == IDLE) && is_mem && misalign) begin
         mem_wreg     = 1'b0;
         mem_addr_err = 1'b1;
      end else if ((state == IDLE) && sc_fail) begin
         mem_wreg  = 1'b1;
         mem_wdata = 32'h0;
      end
      if (timeout) begin
         mem_wreg    = 1'b0;
         mem_bus_err = 1'b1;
      end
      if (done || (state == HOLD)) begin
         if (is_load) mem_wdata = ld_data;
         if (is_sc)   mem_wdata = 32'h1;
         mem_LLbit_we    = link_en & (is_ll | is_sc);
         mem_LLbit_value = link_en & is_ll;
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed + randomized bench for mem_lsu against a behavioural model.
module tb_mem_lsu;

   localparam int unsigned TO = 4;
   localparam logic [7:0] LB = 8'b1110_0000, LBU = 8'b1110_0100, LH = 8'b1110_0001,
                          LHU = 8'b1110_0101, LW = 8'b1110_0011, LL = 8'b1111_0000,
                          SB = 8'b1110_1000, SH = 8'b1110_1001, SW = 8'b1110_1011,
                          SC = 8'b1111_1000, NOP = 8'h00, OR_OP = 8'b0010_0101;
`ifdef LSU_LLSC_EN
   localparam bit LLSC = 1'b1;
`else
   localparam bit LLSC = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic mem_wreg_i, mem_whilo_i, LLbit_i, wb_LLbit_we, wb_LLbit_value, dbus_ack;
   logic [4:0]  mem_wd_i;
   logic [31:0] mem_wdata_i, mem_hi_i, mem_lo_i, mem_addr_i, mem_reg2_i, dbus_rdata;
   logic [7:0]  mem_aluop_i;
   logic [5:0]  stall;
   logic dbus_req, dbus_we, mem_wreg, mem_whilo, mem_LLbit_we, mem_LLbit_value;
   logic mem_addr_err, mem_bus_err, stallreq;
   logic [31:0] dbus_addr, dbus_wdata, mem_wdata, mem_hi, mem_lo;
   logic [3:0]  dbus_sel;
   logic [4:0]  mem_wd;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_lsu #(.BUS_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
      .mem_whilo_i(mem_whilo_i), .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i),
      .mem_aluop_i(mem_aluop_i), .mem_addr_i(mem_addr_i), .mem_reg2_i(mem_reg2_i),
      .stall(stall), .LLbit_i(LLbit_i), .wb_LLbit_we(wb_LLbit_we),
      .wb_LLbit_value(wb_LLbit_value), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
      .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_sel(dbus_sel),
      .dbus_wdata(dbus_wdata), .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
      .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
      .mem_LLbit_we(mem_LLbit_we), .mem_LLbit_value(mem_LLbit_value),
      .mem_addr_err(mem_addr_err), .mem_bus_err(mem_bus_err), .stallreq(stallreq)
   );

   typedef struct {
      bit          bus;
      bit          we;
      logic [3:0]  sel;
      logic [31:0] bwdata;
      bit          aerr;
      logic        wreg;
      logic [31:0] wdata;
      bit          llwe;
      bit          llval;
   } exp_t;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Behavioural model: what the MEM stage must present for one memory instruction
   function automatic exp_t model(input logic [7:0] op, input logic [31:0] addr, rt, word, win,
                                  input logic wreg, input logic llb);
      exp_t e;
      int size, off;
      bit ld, sgn;
      logic [31:0] v, mask;
      e.bus = 0; e.we = 0; e.sel = 4'h0; e.bwdata = 32'h0; e.aerr = 0;
      e.wreg = wreg; e.wdata = win; e.llwe = 0; e.llval = 0;
      size = 0; ld = 0; sgn = 0;
      case (op)
         LB:  begin size = 1; ld = 1; sgn = 1; end
         LBU: begin size = 1; ld = 1; end
         LH:  begin size = 2; ld = 1; sgn = 1; end
         LHU: begin size = 2; ld = 1; end
         LW, LL: begin size = 4; ld = 1; end
         SB:  size = 1;
         SH:  size = 2;
         SW, SC: size = 4;
         default: size = 0;
      endcase
      if (size == 0) return e;
      off = int'(addr % 32'd4);
      if (off % size != 0) begin
         e.aerr = 1; e.wreg = 1'b0;
         return e;
      end
      if (LLSC && op == SC && !llb) begin
         e.wdata = 32'h0; e.wreg = 1'b1;
         return e;
      end
      e.bus = 1;
      e.we  = !ld;
      e.sel = 4'(((1 << size) - 1) << (4 - size - off));
      if (size == 1)      e.bwdata = 32'(rt[7:0]) * 32'h0101_0101;
      else if (size == 2) e.bwdata = 32'(rt[15:0]) * 32'h0001_0001;
      else                e.bwdata = rt;
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      v = (word >> (8 * (4 - size - off))) & mask;
      if (sgn && v[8 * size - 1]) v = v | ~mask;
      if (ld)            e.wdata = v;
      else if (op == SC) e.wdata = 32'h1;
      e.llwe  = LLSC && (op == LL || op == SC);
      e.llval = LLSC && (op == LL);
      return e;
   endfunction

   // One instruction through MEM: issue, bus wait / ack / timeout, optional hold, then idle
   task automatic run_txn(input string tag, input logic [7:0] op, input logic [31:0] addr, rt, word,
                          input logic wreg, input int delay, input int hold);
      exp_t e;
      logic [31:0] win, wnext;
      win = $urandom;
      e = model(op, addr, rt, word, win, wreg, wb_LLbit_we ? wb_LLbit_value : LLbit_i);
      mem_aluop_i = op; mem_addr_i = addr; mem_reg2_i = rt; mem_wdata_i = win;
      mem_wreg_i = wreg; mem_wd_i = 5'($urandom); dbus_ack = 1'b0; stall = 6'h00;
      dbus_rdata = ~word;
      @(negedge clk);
      chk({tag, ".req"}, 32'(dbus_req), 32'(e.bus));
      chk({tag, ".stallreq_issue"}, 32'(stallreq), 32'(e.bus));
      if (!e.bus) begin
         chk({tag, ".addr_err"}, 32'(mem_addr_err), 32'(e.aerr));
         chk({tag, ".wreg"}, 32'(mem_wreg), 32'(e.wreg));
         chk({tag, ".wdata"}, mem_wdata, e.wdata);
         chk({tag, ".llwe"}, 32'(mem_LLbit_we), 32'(0));
         @(posedge clk); #1;
         return;
      end
      chk({tag, ".we"}, 32'(dbus_we), 32'(e.we));
      chk({tag, ".addr"}, dbus_addr, {addr[31:2], 2'b00});
      chk({tag, ".sel"}, 32'(dbus_sel), 32'(e.sel));
      if (e.we) chk({tag, ".bwdata"}, dbus_wdata, e.bwdata);
      @(posedge clk); #1;
      for (int k = 0; k <= int'(TO); k++) begin
         if (k == int'(TO)) begin
            @(negedge clk);
            chk({tag, ".to_req"}, 32'(dbus_req), 32'(0));
            chk({tag, ".to_err"}, 32'(mem_bus_err), 32'(1));
            chk({tag, ".to_wreg"}, 32'(mem_wreg), 32'(0));
            chk({tag, ".to_stallreq"}, 32'(stallreq), 32'(0));
            @(posedge clk); #1;
            break;
         end
         if (k == delay) begin
            dbus_ack = 1'b1; dbus_rdata = word; stall = (hold > 0) ? 6'h3F : 6'h00;
            @(negedge clk);
            chk({tag, ".ack_stallreq"}, 32'(stallreq), 32'(0));
            chk({tag, ".ack_wdata"}, mem_wdata, e.wdata);
            chk({tag, ".ack_wreg"}, 32'(mem_wreg), 32'(e.wreg));
            chk({tag, ".ack_llwe"}, 32'(mem_LLbit_we), 32'(e.llwe));
            chk({tag, ".ack_llval"}, 32'(mem_LLbit_value), 32'(e.llval));
            chk({tag, ".ack_buserr"}, 32'(mem_bus_err), 32'(0));
            @(posedge clk); #1;
            dbus_ack = 1'b0;
            for (int h = 0; h < hold; h++) begin
               dbus_rdata = $urandom;
               stall = (h == hold - 1) ? 6'h00 : 6'h3F;
               @(negedge clk);
               chk({tag, ".hold_wdata"}, mem_wdata, e.wdata);
               chk({tag, ".hold_req"}, 32'(dbus_req), 32'(0));
               chk({tag, ".hold_stallreq"}, 32'(stallreq), 32'(0));
               @(posedge clk); #1;
            end
            break;
         end
         @(negedge clk);
         chk({tag, ".wait_req"}, 32'(dbus_req), 32'(1));
         chk({tag, ".wait_stallreq"}, 32'(stallreq), 32'(1));
         chk({tag, ".wait_sel"}, 32'(dbus_sel), 32'(e.sel));
         @(posedge clk); #1;
      end
      stall = 6'h00; dbus_ack = 1'b0;
      wnext = $urandom;
      mem_aluop_i = NOP; mem_wdata_i = wnext;
      @(negedge clk);
      chk({tag, ".idle_req"}, 32'(dbus_req), 32'(0));
      chk({tag, ".idle_wdata"}, mem_wdata, wnext);
      @(posedge clk); #1;
   endtask

   function automatic logic [7:0] pick_op(input int unsigned i);
      case (i)
         0: return LB;   1: return LBU;  2: return LH;  3: return LHU;
         4: return LW;   5: return LL;   6: return SB;  7: return SH;
         8: return SW;   9: return SC;   default: return OR_OP;
      endcase
   endfunction

   initial begin
      logic [31:0] w;
      rst = 1'b0; mem_wreg_i = 1'b0; mem_wd_i = 5'd0; mem_wdata_i = 32'h0;
      mem_whilo_i = 1'b0; mem_hi_i = 32'h0; mem_lo_i = 32'h0; mem_aluop_i = NOP;
      mem_addr_i = 32'h0; mem_reg2_i = 32'h0; stall = 6'h00; LLbit_i = 1'b0;
      wb_LLbit_we = 1'b0; wb_LLbit_value = 1'b0; dbus_ack = 1'b0; dbus_rdata = 32'h0;

      // Reset state
      @(posedge clk); #1;
      @(negedge clk);
      chk("reset.req", 32'(dbus_req), 32'(0));
      chk("reset.stallreq", 32'(stallreq), 32'(0));
      chk("reset.buserr", 32'(mem_bus_err), 32'(0));
      @(posedge clk); #1;
      rst = 1'b1;

      // Directed cases
      run_txn("lb_103", LB, 32'h0000_0103, 32'h0, 32'h1122_3380, 1'b1, 2, 0);
      run_txn("sh_202", SH, 32'h0000_0202, 32'h0000_BEEF, 32'h0, 1'b0, 0, 0);
      run_txn("lw_mis", LW, 32'h0000_0101, 32'h0, 32'h0, 1'b1, 0, 0);
      run_txn("lh_mis", LH, 32'h0000_0203, 32'h0, 32'h0, 1'b1, 0, 0);
      run_txn("ll_40", LL, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 1'b1, 1, 0);
      LLbit_i = 1'b1; wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b0;
      run_txn("sc_fwd0", SC, 32'h0000_0040, 32'h1234_5678, 32'h0, 1'b1, 1, 0);
      wb_LLbit_we = 1'b0;
      run_txn("sc_ok", SC, 32'h0000_0040, 32'h1234_5678, 32'h0, 1'b1, 0, 0);
      run_txn("lw_timeout", LW, 32'h0000_0080, 32'h0, 32'h5555_AAAA, 1'b1, 9, 0);
      run_txn("lhu_hold", LHU, 32'h0000_0206, 32'h0, 32'h89AB_CDEF, 1'b1, 1, 3);
      run_txn("lbu_2", LBU, 32'h0000_0302, 32'h0, 32'h0011_FF33, 1'b1, 3, 1);

      // Non-memory op passes straight through
      mem_aluop_i = OR_OP; mem_wreg_i = 1'b1; mem_wd_i = 5'd17; mem_wdata_i = 32'hA5A5_0F0F;
      mem_whilo_i = 1'b1; mem_hi_i = 32'h1357_9BDF; mem_lo_i = 32'h2468_ACE0;
      mem_addr_i = 32'h0000_0001;
      @(negedge clk);
      chk("pass.wreg", 32'(mem_wreg), 32'(1));
      chk("pass.wd", 32'(mem_wd), 32'(17));
      chk("pass.wdata", mem_wdata, 32'hA5A5_0F0F);
      chk("pass.whilo", 32'(mem_whilo), 32'(1));
      chk("pass.hi", mem_hi, 32'h1357_9BDF);
      chk("pass.lo", mem_lo, 32'h2468_ACE0);
      chk("pass.req", 32'(dbus_req), 32'(0));
      chk("pass.stallreq", 32'(stallreq), 32'(0));
      chk("pass.addr_err", 32'(mem_addr_err), 32'(0));
      @(posedge clk); #1;

      // Reset in the middle of a bus access; a late ack must be ignored
      mem_aluop_i = LW; mem_addr_i = 32'h0000_0300;
      @(negedge clk);
      chk("rstmid.issue_req", 32'(dbus_req), 32'(1));
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1; mem_aluop_i = NOP; mem_wdata_i = 32'h0BAD_F00D;
      dbus_ack = 1'b1; dbus_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("rstmid.req", 32'(dbus_req), 32'(0));
      chk("rstmid.we", 32'(dbus_we), 32'(0));
      chk("rstmid.sel", 32'(dbus_sel), 32'(0));
      chk("rstmid.addr", dbus_addr, 32'h0);
      chk("rstmid.stallreq", 32'(stallreq), 32'(0));
      chk("rstmid.wdata", mem_wdata, 32'h0BAD_F00D);
      @(posedge clk); #1;
      dbus_ack = 1'b0;

      // Randomized mix
      for (int i = 0; i < 60; i++) begin
         LLbit_i = 1'($urandom); wb_LLbit_we = 1'($urandom); wb_LLbit_value = 1'($urandom);
         w = $urandom;
         run_txn($sformatf("rnd%0d", i), pick_op($urandom_range(0, 10)), $urandom, $urandom, w,
                 1'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 2)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
